fft_driver: RTL and testbench
=============================

FFT_DRIVER -- requirements
Module: fft_driver

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 10, meaning the cycle count from the b2 pulse to the first result capture; legal range 9..31.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a request to run a batch of butterflies; sampled only in IDLE.
REQ-005 SHALL have port nbf, input, 4, the number of butterflies in the batch, captured on an accepted start.
REQ-006 SHALL have port w1, input, 8, twiddle word 1, captured on an accepted start.
REQ-007 SHALL have port w2, input, 8, twiddle word 2, captured on an accepted start.
REQ-008 SHALL have port din, input, 8, a sample byte, sent in order a1, a2, b1, b2 per butterfly.
REQ-009 SHALL have port din_valid, input, 1, meaning din holds a valid byte.
REQ-010 SHALL have port din_ready, output, 1, meaning the driver accepts din this cycle.
REQ-011 SHALL have port bf_inp, output, 8, the byte driven to the butterfly data input.
REQ-012 SHALL have port bf_readyin, output, 1, the step strobe to the butterfly; the butterfly edge-detects it.
REQ-013 SHALL have port bf_out, input, 8, the butterfly result byte.
REQ-014 SHALL have port dout, output, 8, the captured result byte.
REQ-015 SHALL have port dout_idx, output, 2, the result index: 0=y1, 1=y2, 2=z1, 3=z2.
REQ-016 SHALL have port dout_valid, output, 1, a one-cycle strobe meaning dout and dout_idx are valid.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, a one-cycle strobe marking the end of a batch.

Function
REQ-019 SHALL drive bf_inp, bf_readyin, dout, dout_idx, dout_valid and done from registers.
REQ-020 SHALL implement the states IDLE, PRIME, LOAD, WAIT, UNLOAD and FIN.
REQ-021 SHALL, in IDLE with start=1, capture nbf, w1 and w2, then go to FIN if nbf=0, to LOAD if primed=1, or to PRIME otherwise.
REQ-022 SHALL, in PRIME, issue 3 pulses with bf_inp = 0x00, w1, w2, then set primed=1 and go to LOAD.
REQ-023 SHALL make every pulse bf_readyin=1 for exactly one cycle, followed by at least one cycle of bf_readyin=0.
REQ-024 SHALL hold bf_inp stable during each pulse cycle.
REQ-025 SHALL, in LOAD, assert din_ready only when no pulse is in progress and no gap cycle is pending.
REQ-026 SHALL, on din_valid and din_ready, set bf_inp <= din and bf_readyin <= 1 in the next cycle.
REQ-027 SHALL leave bf_readyin at 0 and issue no pulse while din_valid=0 in LOAD.
REQ-028 SHALL go to WAIT after the 4th accepted byte (b2).
REQ-029 SHALL, in WAIT, count so that the first UNLOAD pulse cycle is exactly WAIT_CYC cycles after the b2 pulse cycle.
REQ-030 SHALL, in UNLOAD, issue 4 pulses with bf_inp = 0x00.
REQ-031 SHALL, in each UNLOAD pulse cycle, sample bf_out into dout and set dout_idx to 0, 1, 2, 3 in turn.
REQ-032 SHALL assert dout_valid in the cycle after each UNLOAD pulse.
REQ-033 SHALL NOT support backpressure on dout.
REQ-034 SHALL, after the 4th UNLOAD pulse, decrement the remaining-butterfly count and go to LOAD if it is nonzero, or to FIN otherwise.
REQ-035 SHALL, in FIN, assert done for one cycle and go to IDLE.
REQ-036 SHALL ignore start when not in IDLE.
REQ-037 SHALL leave start asserted in the FIN cycle without effect; start is sampled again in IDLE.
REQ-038 SHALL NOT re-prime within one reset period; twiddle values presented on later starts are ignored.
REQ-039 SHALL pass bf_out to dout unmodified at 8 bits; the driver does no arithmetic.

Reset
REQ-040 SHALL, on rst=1 at a clock edge, go to IDLE and clear primed, the remaining count and all registers.
REQ-041 SHALL, during reset, drive every output to 0, including din_ready=0 and busy=0.
REQ-042 SHALL let rst override every state, including mid-pulse; the system resets the butterfly in the same cycle.
REQ-043 SHALL, after reset, PRIME again on the next accepted start.

Verification
REQ-044 SHALL cover first run: after reset, start with nbf=1, w1=2, w2=0, and din bytes 5, 0, 3, 0 -> bf_inp pulses 0, 2, 0, 5, 0, 3, 0 and dout y1=11, y2=0, z1=255 (-1), z2=0 with dout_idx 0..3, then done.
REQ-045 SHALL cover a second start without reset -> no PRIME pulses, first pulse carries a1, twiddle inputs ignored.
REQ-046 SHALL cover nbf=3 with din_valid toggled randomly -> 12 accepted bytes, 12 dout_valid strobes, one done, no bf_readyin high for 2 consecutive cycles.
REQ-047 SHALL cover nbf=0 -> done in the cycle after FIN is reached, no bf_readyin pulse, no din_ready.
REQ-048 SHALL cover rst asserted during UNLOAD after 2 results -> next cycle all outputs 0 and busy=0; the next start issues 3 PRIME pulses.
REQ-049 SHALL cover WAIT_CYC=12 -> the first UNLOAD pulse occurs exactly 12 cycles after the b2 pulse, checked against a butterfly model.

Source files
------------

// File: rtl/fft_driver.sv
// fft_driver: sequences twiddle priming, sample loading and result unloading
// for an edge-triggered, byte-serial radix-2 butterfly.
module fft_driver #(
   parameter int WAIT_CYC = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] nbf,
   input  logic [7:0] w1,
   input  logic [7:0] w2,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [7:0] bf_inp,
   output logic       bf_readyin,
   input  logic [7:0] bf_out,
   output logic [7:0] dout,
   output logic [1:0] dout_idx,
   output logic       dout_valid,
   output logic       busy,
   output logic       done
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRIME  = 3'd1,
      LOAD   = 3'd2,
      WAIT   = 3'd3,
      UNLOAD = 3'd4,
      FIN    = 3'd5
   } state_t;

   // WAIT counts from 0 in the b2 pulse cycle; leaving one cycle early lets UNLOAD
   // register its first pulse so it lands exactly WAIT_CYC cycles after b2.
   localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYC - 2);

   state_t     state_r;
   logic       primed_r;
   logic [3:0] rem_r;
   logic [7:0] w1_r;
   logic [7:0] w2_r;
   logic [1:0] step_r;
   logic [4:0] wcnt_r;
   logic [7:0] bf_inp_r;
   logic       bf_readyin_r;
   logic [7:0] dout_r;
   logic [1:0] dout_idx_r;
   logic       dout_valid_r;
   logic       done_r;
   logic       accept_s;

   // A byte is only taken when the previous pulse has dropped, which guarantees a gap cycle.
   assign din_ready = (state_r == LOAD) && !bf_readyin_r && !rst;
   assign busy      = (state_r != IDLE) && !rst;
   assign accept_s  = din_valid && din_ready;

   // Main sequencer: state, counters and every registered butterfly/result output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         primed_r     <= 1'b0;
         rem_r        <= 4'd0;
         w1_r         <= 8'h00;
         w2_r         <= 8'h00;
         step_r       <= 2'd0;
         wcnt_r       <= 5'd0;
         bf_inp_r     <= 8'h00;
         bf_readyin_r <= 1'b0;
         dout_r       <= 8'h00;
         dout_idx_r   <= 2'd0;
         dout_valid_r <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         dout_valid_r <= 1'b0;
         done_r       <= 1'b0;
         case (state_r)
            IDLE: begin
               bf_readyin_r <= 1'b0;
               if (start) begin
                  rem_r  <= nbf;
                  step_r <= 2'd0;
                  if (!primed_r) begin
                     w1_r <= w1;
                     w2_r <= w2;
                  end
                  if (nbf == 4'd0)
                     state_r <= FIN;
                  else if (primed_r)
                     state_r <= LOAD;
                  else
                     state_r <= PRIME;
               end
            end
            PRIME: begin
               if (bf_readyin_r) begin
                  bf_readyin_r <= 1'b0;
                  if (step_r == 2'd3) begin
                     primed_r <= 1'b1;
                     step_r   <= 2'd0;
                     state_r  <= LOAD;
                  end
               end else begin
                  bf_readyin_r <= 1'b1;
                  step_r       <= step_r + 2'd1;
                  case (step_r)
                     2'd1:    bf_inp_r <= w1_r;
                     2'd2:    bf_inp_r <= w2_r;
                     default: bf_inp_r <= 8'h00;
                  endcase
               end
            end
            LOAD: begin
               if (accept_s) begin
                  bf_inp_r     <= din;
                  bf_readyin_r <= 1'b1;
                  step_r       <= step_r + 2'd1;
                  if (step_r == 2'd3) begin
                     wcnt_r  <= 5'd0;
                     state_r <= WAIT;
                  end
               end else begin
                  bf_readyin_r <= 1'b0;
               end
            end
            WAIT: begin
               bf_readyin_r <= 1'b0;
               wcnt_r       <= wcnt_r + 5'd1;
               if (wcnt_r == WAIT_LAST) begin
                  step_r  <= 2'd0;
                  state_r <= UNLOAD;
               end
            end
            UNLOAD: begin
               if (bf_readyin_r) begin
                  bf_readyin_r <= 1'b0;
                  dout_r       <= bf_out;
                  dout_idx_r   <= step_r;
                  dout_valid_r <= 1'b1;
                  step_r       <= step_r + 2'd1;
                  if (step_r == 2'd3) begin
                     rem_r   <= rem_r - 4'd1;
                     state_r <= (rem_r == 4'd1) ? FIN : LOAD;
                  end
               end else begin
                  bf_inp_r     <= 8'h00;
                  bf_readyin_r <= 1'b1;
               end
            end
            FIN: begin
               bf_readyin_r <= 1'b0;
               done_r       <= 1'b1;
               state_r      <= IDLE;
            end
            default: begin
               bf_readyin_r <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

   assign bf_inp     = bf_inp_r;
   assign bf_readyin = bf_readyin_r;
   assign dout       = dout_r;
   assign dout_idx   = dout_idx_r;
   assign dout_valid = dout_valid_r;
   assign done       = done_r;
endmodule

// File: tb/tb_fft_driver.sv
// Bench for fft_driver: behavioural butterfly plus pulse/result scoreboards.
module tb_fft_driver;
   localparam int WC = 12;

   logic       clk = 1'b0;
   logic       rst, start, din_valid;
   logic [3:0] nbf;
   logic [7:0] w1, w2, din;
   logic       din_ready, bf_readyin, dout_valid, busy, done;
   logic [7:0] bf_inp, bf_out, dout;
   logic [1:0] dout_idx;

   always #5 clk = ~clk;

   fft_driver #(.WAIT_CYC(WC)) dut (
      .clk(clk), .rst(rst), .start(start), .nbf(nbf), .w1(w1), .w2(w2),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .bf_inp(bf_inp), .bf_readyin(bf_readyin), .bf_out(bf_out),
      .dout(dout), .dout_idx(dout_idx), .dout_valid(dout_valid),
      .busy(busy), .done(done)
   );

   int n_vec = 0, n_err = 0;
   int cyc = 0, b2_cyc = 0, acc_cnt = 0, dv_cnt = 0, done_cnt = 0;
   logic rin_prev = 1'b0;
   logic [7:0]  exp_pulse[$];
   logic [9:0]  exp_out[$];
   logic [7:0]  src[$];
   bit          tb_primed = 1'b0;
   logic [7:0]  tb_w1, tb_w2;
   logic [8:0]  ep;
   logic [10:0] eo;

   function automatic logic [31:0] bf_ref(input logic [7:0] a1, a2, b1, b2, wr, wi);
      logic [7:0] tr, ti;
      tr = wr * b1 - wi * b2;
      ti = wr * b2 + wi * b1;
      return {a1 + tr, a2 + ti, a1 - tr, a2 - ti};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Butterfly model: primes on its first three strobes, then 4 inputs / 4 outputs.
   logic [2:0] m_step, m_ph;
   logic       m_primed, m_rin_d;
   logic [7:0] m_wr, m_wi, m_a1, m_a2, m_b1, m_b2;
   logic [31:0] m_res;
   always @(posedge clk) begin
      if (rst) begin
         m_step <= 3'd0; m_ph <= 3'd0; m_primed <= 1'b0; m_rin_d <= 1'b0;
      end else begin
         m_rin_d <= bf_readyin;
         if (bf_readyin && !m_rin_d) begin
            if (!m_primed) begin
               if (m_step == 3'd1) m_wr <= bf_inp;
               if (m_step == 3'd2) begin m_wi <= bf_inp; m_primed <= 1'b1; end
               m_step <= m_step + 3'd1;
            end else begin
               case (m_ph)
                  3'd0: m_a1 <= bf_inp;
                  3'd1: m_a2 <= bf_inp;
                  3'd2: m_b1 <= bf_inp;
                  3'd3: m_b2 <= bf_inp;
                  default: ;
               endcase
               m_ph <= m_ph + 3'd1;
            end
         end
      end
   end
   always_comb begin
      m_res  = bf_ref(m_a1, m_a2, m_b1, m_b2, m_wr, m_wi);
      bf_out = 8'hEE;
      if (m_primed) begin
         case (m_ph)
            3'd4: bf_out = m_res[31:24];
            3'd5: bf_out = m_res[23:16];
            3'd6: bf_out = m_res[15:8];
            3'd7: bf_out = m_res[7:0];
            default: bf_out = 8'hEE;
         endcase
      end
   end

   // Monitor: pulse shape and payload, WAIT latency, result scoreboard, event counts.
   always @(negedge clk) begin
      cyc++;
      if (bf_readyin === 1'b1) begin
         chk("pulse_gap", 32'(rin_prev), 32'd0);
         if (exp_pulse.size() > 0) ep = {1'b0, exp_pulse.pop_front()};
         else ep = 9'h100;
         chk("bf_inp", 32'({1'b0, bf_inp}), 32'(ep));
         if (m_primed && m_ph == 3'd3) b2_cyc = cyc;
         if (m_primed && m_ph == 3'd4) chk("wait_cyc", 32'(cyc - b2_cyc), 32'(WC));
      end
      if (dout_valid === 1'b1) begin
         if (exp_out.size() > 0) eo = {1'b0, exp_out.pop_front()};
         else eo = 11'h400;
         chk("dout", 32'({1'b0, dout_idx, dout}), 32'(eo));
         dv_cnt++;
      end
      if (din_valid && din_ready) acc_cnt++;
      if (done === 1'b1) done_cnt++;
      rin_prev = bf_readyin;
   end

   task automatic fill_src(input int n);
      src.delete();
      for (int i = 0; i < 4 * n; i++) src.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic run_batch(input logic [3:0] n, input logic [7:0] tw1, tw2, input bit rnd,
                            input int abort_after, input bit use_lit, input logic [31:0] lit);
      int a0, d0, k0, k, guard, nb;
      bit acc;
      logic [31:0] r;
      nb = 4 * int'(n);
      if (!tb_primed) begin
         exp_pulse.push_back(8'h00); exp_pulse.push_back(tw1); exp_pulse.push_back(tw2);
         tb_primed = 1'b1; tb_w1 = tw1; tb_w2 = tw2;
      end
      for (int i = 0; i < int'(n); i++) begin
         for (int j = 0; j < 4; j++) exp_pulse.push_back(src[4*i+j]);
         for (int j = 0; j < 4; j++) exp_pulse.push_back(8'h00);
         r = use_lit ? lit : bf_ref(src[4*i], src[4*i+1], src[4*i+2], src[4*i+3], tb_w1, tb_w2);
         exp_out.push_back({2'd0, r[31:24]});
         exp_out.push_back({2'd1, r[23:16]});
         exp_out.push_back({2'd2, r[15:8]});
         exp_out.push_back({2'd3, r[7:0]});
      end
      a0 = acc_cnt; d0 = dv_cnt; k0 = done_cnt;
      @(posedge clk); #1; start = 1'b1; nbf = n; w1 = tw1; w2 = tw2;
      @(posedge clk); #1; start = 1'b0; nbf = 4'hF; w1 = 8'hA5; w2 = 8'h5A;
      k = 0; guard = 0;
      while (k < nb && guard < 2000) begin
         din = src[k];
         din_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         @(negedge clk); acc = din_valid && din_ready;
         @(posedge clk); #1;
         if (acc) k++;
         guard++;
      end
      din_valid = 1'b0;
      chk("bytes_fed", 32'(k), 32'(nb));
      guard = 0;
      if (abort_after > 0) begin
         while (dv_cnt - d0 < abort_after && guard < 400) begin @(negedge clk); #1; guard++; end
         chk("abort_reach", 32'(dv_cnt - d0), 32'(abort_after));
         rst = 1'b1;
         @(posedge clk); #1; rst = 1'b0;
         @(negedge clk);
         chk("rst_mid_outs", 32'({bf_inp, bf_readyin, dout, dout_idx, dout_valid, done, busy, din_ready}), 32'd0);
         exp_pulse.delete(); exp_out.delete(); tb_primed = 1'b0;
      end else begin
         while (done_cnt == k0 && guard < 600) begin @(negedge clk); #1; guard++; end
         chk("done_cnt", 32'(done_cnt - k0), 32'd1);
         chk("dv_cnt", 32'(dv_cnt - d0), 32'(nb));
         chk("acc_cnt", 32'(acc_cnt - a0), 32'(nb));
         chk("queues_empty", 32'(exp_pulse.size() + exp_out.size()), 32'd0);
         @(negedge clk);
         chk("idle_after_done", 32'({done, busy}), 32'd0);
      end
   endtask

   initial begin
      int k0;
      rst = 1'b1; start = 1'b0; nbf = 4'd0; w1 = 8'h00; w2 = 8'h00; din = 8'h00; din_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 32'({bf_inp, bf_readyin, dout, dout_idx, dout_valid, done, busy, din_ready}), 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // First run: prime with w=2+0j, a=5+0j, b=3+0j -> y=11, z=-1.
      src.delete();
      src.push_back(8'd5); src.push_back(8'd0); src.push_back(8'd3); src.push_back(8'd0);
      run_batch(4'd1, 8'd2, 8'd0, 1'b0, 0, 1'b1, {8'd11, 8'd0, 8'd255, 8'd0});

      // Second start: no priming, new twiddles ignored.
      fill_src(2);
      run_batch(4'd2, 8'd7, 8'd9, 1'b0, 0, 1'b0, 32'd0);

      // Three butterflies with a randomly stalling source.
      fill_src(3);
      run_batch(4'd3, 8'd1, 8'd1, 1'b1, 0, 1'b0, 32'd0);

      // Empty batch, start held through FIN.
      k0 = done_cnt;
      @(posedge clk); #1; start = 1'b1; nbf = 4'd0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("nbf0_fin", 32'({busy, done, din_ready, bf_readyin}), 32'h8);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("nbf0_done", 32'({busy, done, din_ready, bf_readyin}), 32'h4);
      @(negedge clk);
      chk("nbf0_idle", 32'({busy, done, din_ready, bf_readyin}), 32'h0);
      #1;
      chk("nbf0_done_cnt", 32'(done_cnt - k0), 32'd1);

      // Reset in UNLOAD after two results, then a fresh start must prime again.
      fill_src(1);
      run_batch(4'd1, 8'd0, 8'd0, 1'b0, 2, 1'b0, 32'd0);
      fill_src(1);
      run_batch(4'd1, 8'd3, 8'd1, 1'b0, 0, 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end
endmodule
